load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_ABITS, 22, width of the data-memory word address; byte address width is MEM_ABITS+2.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  CPU load/store request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  MEM_ABITS+2  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected (misaligned or illegal size), valid with resp_valid.
REQ-014 mem_addr  output  MEM_ABITS  word address to data memory, = latched req_addr[MEM_ABITS+1:2].
REQ-015 mem_wdata  output  32  word written to data memory.
REQ-016 mem_we  output  1  data-memory write enable.
REQ-017 mem_rdata  input  32  combinational read data from data memory at mem_addr.

Function
REQ-018 FSM states: IDLE, LOAD, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Handshake: request accepted on a clk edge where req_valid & req_ready; all req_* fields latched at that edge.
REQ-020 Error check at acceptance: size 11, halfword with addr[0]=1, or word with addr[1:0]!=00 -> RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-021 Load (legal): IDLE -> LOAD -> RESP; in LOAD mem_we=0, mem_rdata captured, lane selected, extended to 32 bits.
REQ-022 Word store (legal): IDLE -> WRITE -> RESP; in WRITE mem_we=1, mem_wdata = latched req_wdata.
REQ-023 Sub-word store (legal): IDLE -> READ -> WRITE -> RESP; READ captures mem_rdata; WRITE writes that word with only the addressed lane(s) replaced.
REQ-024 Byte lanes little-endian: addr[1:0]=0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]; halfword at addr[1]=0 -> [15:0], 1 -> [31:16].
REQ-025 Latency from acceptance edge N: error resp_valid high in cycle N+1; load and word store N+2; sub-word store N+3.
REQ-026 RESP lasts exactly one cycle (resp_valid=1) then returns to IDLE; a new request is accepted no earlier than the following cycle; no response backpressure.
REQ-027 resp_valid, resp_err and resp_rdata are registered; resp_rdata and resp_err are 0 whenever resp_valid=0.
REQ-028 mem_we SHALL be 1 only in WRITE and only when reset=1; exactly one write per legal store, none per load or error.
REQ-029 mem_addr held stable from acceptance through RESP; mem_wdata is 0 outside WRITE.
REQ-030 req_valid while not IDLE is ignored and not latched.

Reset
REQ-031 While reset=0 at a clk edge: state <- IDLE, all latched request fields, captured read word, resp_valid, resp_err, resp_rdata <- 0; mem_addr <- 0.
REQ-032 Reset in any state aborts the operation: no response issued, and mem_we is 0 during any cycle where reset=0, so a store interrupted in WRITE performs no write.
REQ-033 First cycle after reset released: req_ready=1, resp_valid=0, mem_we=0.

Verification
REQ-034 Memory word 4 = 0x11223344; load byte, signed, addr 0x12 -> resp_valid at N+2, resp_rdata=0x00000022; same signed at addr 0x13 with word 0x80FF0000 -> 0xFFFFFF80.
REQ-035 Store byte 0xAB to addr 0x11 over word 0x11223344 -> READ then WRITE, mem_addr=4, mem_wdata=0x1122AB44, single mem_we pulse, resp_valid at N+3, resp_rdata=0.
REQ-036 Store word 0xDEADBEEF to addr 0x20 -> mem_we pulse in N+1 with mem_addr=8, resp_valid at N+2; load half unsigned addr 0x22 -> 0x0000DEAD.
REQ-037 Load word addr 0x06 and size=11 request -> resp_valid at N+1, resp_err=1, resp_rdata=0, mem_we never asserted.
REQ-038 Store halfword accepted, reset=0 asserted during WRITE cycle -> mem_we=0 that cycle, memory unchanged, no resp_valid, req_ready=1 first cycle after release.
REQ-039 req_valid held high continuously with back-to-back legal requests -> acceptances only in IDLE, one response per accepted request, none dropped or duplicated.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-ported, word-wide data memory.
// Sub-word stores use a read-modify-write, and misaligned or illegal requests are answered with an error.
module load_store_unit #(
    parameter int MEM_ABITS = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [MEM_ABITS+1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [MEM_ABITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    input  logic [31:0]          mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [1:0]             r_size;
    logic                   r_signed;
    logic [1:0]             r_offset;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdword;
    logic [MEM_ABITS-1:0]   r_mem_addr;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic [31:0]            r_resp_rdata;

    logic                   w_accept;
    logic                   w_illegal;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load_data;
    logic [31:0]            w_merged;

    assign w_accept = req_valid && (r_state == IDLE);

    always_comb begin
        w_illegal = 1'b0;
        case (req_size)
            SZ_HALF: w_illegal = req_addr[0];
            SZ_WORD: w_illegal = |req_addr[1:0];
            SZ_ILL:  w_illegal = 1'b1;
            default: w_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next = RESP;
                    end else if (!req_write) begin
                        w_next = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            LOAD:    w_next = RESP;
            READ:    w_next = WRITE;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The write strobe is qualified by reset so a store caught by reset in WRITE never reaches memory.
    always_comb begin
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (r_state == IDLE) begin
            req_ready = 1'b1;
        end
        if ((r_state == WRITE) && reset) begin
            mem_we    = 1'b1;
            mem_wdata = w_merged;
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_offset)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        w_load_data = mem_rdata;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Word stores go straight from IDLE to WRITE, so r_rdword is only trusted for sub-word sizes.
    always_comb begin
        w_merged = r_rdword;
        case (r_size)
            SZ_BYTE: begin
                case (r_offset)
                    2'd0: w_merged[7:0]   = r_wdata[7:0];
                    2'd1: w_merged[15:8]  = r_wdata[7:0];
                    2'd2: w_merged[23:16] = r_wdata[7:0];
                    2'd3: w_merged[31:24] = r_wdata[7:0];
                    default: w_merged = r_rdword;
                endcase
            end
            SZ_HALF: begin
                if (r_offset[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_rdword     <= '0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_offset   <= req_addr[1:0];
                r_wdata    <= req_wdata;
                r_mem_addr <= req_addr[MEM_ABITS+1:2];
            end
            if ((r_state == LOAD) || (r_state == READ)) begin
                r_rdword <= mem_rdata;
            end
            r_resp_valid <= (w_next == RESP);
            r_resp_err   <= w_accept && w_illegal;
            r_resp_rdata <= (r_state == LOAD) ? w_load_data : 32'h0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and memory writes,
// and a negedge monitor pops and compares them against what the unit presents.
module tb_load_store_unit;

    localparam int MEM_ABITS = 22;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [MEM_ABITS+1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [MEM_ABITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_we;
    logic [31:0]          mem_rdata;

    logic [31:0] mem [0:255];
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = '0;
    logic [31:0] pokeData = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit holdValid = 1'b0;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [MEM_ABITS-1:0] addr;
        logic [31:0]          data;
        int                   cyc;
    } wr_t;

    resp_t respQ[$];
    wr_t   wrQ[$];

    load_store_unit #(.MEM_ABITS(MEM_ABITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read data memory; bench preloads go through the same write port.
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end else if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        resp_t r;
        wr_t   w;
        if (!reset) begin
            check("mem_we during reset", mem_we, 1'b0);
        end else if (!mem_we) begin
            check("mem_wdata outside write", mem_wdata, 32'h0);
        end
        if (resp_valid) begin
            if (respQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected response: actual err=%0b rdata=%0h required none", resp_err, resp_rdata);
            end else begin
                r = respQ.pop_front();
                check("resp_err", resp_err, r.err);
                check("resp_rdata", resp_rdata, r.data);
                check("resp cycle", cyc, r.cyc);
            end
        end else begin
            check("resp_err while idle", resp_err, 1'b0);
            check("resp_rdata while idle", resp_rdata, 32'h0);
        end
        if (mem_we) begin
            if (wrQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected write: actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
            end else begin
                w = wrQ.pop_front();
                check("write addr", mem_addr, w.addr);
                check("write data", mem_wdata, w.data);
                check("write cycle", cyc, w.cyc);
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic pokeMem(input logic [7:0] a, input logic [31:0] d);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        @(negedge clk);
        pokeEn   = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge following the acceptance edge.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [MEM_ABITS+1:0] addr, input logic [31:0] wd,
                                 input logic expErr, input logic [31:0] expData, input int lat,
                                 input logic [MEM_ABITS-1:0] wAddr, input logic [31:0] wData,
                                 input int wOff);
        resp_t r;
        wr_t   w;
        int    n;
        bit    got;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: actual req_ready=0 required 1");
            req_valid = 1'b0;
            return;
        end
        n = cyc + 1;
        r.err  = expErr;
        r.data = expData;
        r.cyc  = n + lat - 1;
        respQ.push_back(r);
        if (wOff >= 0) begin
            w.addr = wAddr;
            w.data = wData;
            w.cyc  = n + wOff;
            wrQ.push_back(w);
        end
        @(posedge clk);
        @(negedge clk);
        if (!holdValid) req_valid = 1'b0;
    endtask

    task automatic doLoad(input logic [1:0] sz, input logic sg, input logic [MEM_ABITS+1:0] addr,
                          input logic expErr, input logic [31:0] expData);
        applyStimulus(1'b0, sz, sg, addr, 32'h0, expErr, expData, expErr ? 1 : 2, '0, 32'h0, -1);
    endtask

    task automatic doStore(input logic [1:0] sz, input logic [MEM_ABITS+1:0] addr, input logic [31:0] wd,
                           input logic expErr, input logic [MEM_ABITS-1:0] wAddr, input logic [31:0] wData);
        if (expErr) begin
            applyStimulus(1'b1, sz, 1'b0, addr, wd, 1'b1, 32'h0, 1, '0, 32'h0, -1);
        end else if (sz == 2'b10) begin
            applyStimulus(1'b1, sz, 1'b0, addr, wd, 1'b0, 32'h0, 2, wAddr, wData, 0);
        end else begin
            applyStimulus(1'b1, sz, 1'b0, addr, wd, 1'b0, 32'h0, 3, wAddr, wData, 1);
        end
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100; k++) begin
            if (respQ.size() == 0 && wrQ.size() == 0) break;
            @(negedge clk);
        end
        if (respQ.size() != 0 || wrQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: actual pending resp=%0d writes=%0d required 0", respQ.size(), wrQ.size());
            respQ.delete();
            wrQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(negedge clk);
        pokeMem(8'd4, 32'h11223344);
        pokeMem(8'd5, 32'h55667788);
        pokeMem(8'd9, 32'hAAAABBBB);
        reset = 1'b1;
        @(negedge clk);
        check("reset req_ready", req_ready, 1'b1);
        check("reset resp_valid", resp_valid, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_addr", mem_addr, '0);

        // Loads with lane selection and extension
        doLoad(2'b00, 1'b1, 24'h12, 1'b0, 32'h00000022);
        doLoad(2'b10, 1'b0, 24'h10, 1'b0, 32'h11223344);
        waitDrain();
        pokeMem(8'd4, 32'h80FF0000);
        doLoad(2'b00, 1'b1, 24'h13, 1'b0, 32'hFFFFFF80);
        doLoad(2'b00, 1'b0, 24'h13, 1'b0, 32'h00000080);
        doLoad(2'b01, 1'b1, 24'h12, 1'b0, 32'hFFFF80FF);
        doLoad(2'b01, 1'b0, 24'h10, 1'b0, 32'h00000000);
        doLoad(2'b00, 1'b1, 24'h12, 1'b0, 32'hFFFFFFFF);
        waitDrain();
        pokeMem(8'd4, 32'h11223344);

        // Sub-word and word stores
        doStore(2'b00, 24'h11, 32'h000000AB, 1'b0, 22'd4, 32'h1122AB44);
        doLoad(2'b10, 1'b0, 24'h10, 1'b0, 32'h1122AB44);
        doStore(2'b01, 24'h16, 32'h1234BEEF, 1'b0, 22'd5, 32'hBEEF7788);
        doStore(2'b00, 24'h14, 32'hFFFFFF01, 1'b0, 22'd5, 32'hBEEF7701);
        doLoad(2'b10, 1'b0, 24'h14, 1'b0, 32'hBEEF7701);
        doStore(2'b10, 24'h20, 32'hDEADBEEF, 1'b0, 22'd8, 32'hDEADBEEF);
        doLoad(2'b01, 1'b0, 24'h22, 1'b0, 32'h0000DEAD);
        doLoad(2'b00, 1'b1, 24'h20, 1'b0, 32'hFFFFFFEF);
        doLoad(2'b01, 1'b1, 24'h20, 1'b0, 32'hFFFFBEEF);

        // Rejected requests: misaligned and illegal size
        doLoad(2'b10, 1'b0, 24'h06, 1'b1, 32'h0);
        doLoad(2'b11, 1'b0, 24'h00, 1'b1, 32'h0);
        doStore(2'b01, 24'h21, 32'h0000FFFF, 1'b1, '0, 32'h0);
        doStore(2'b10, 24'h22, 32'h12345678, 1'b1, '0, 32'h0);
        doLoad(2'b10, 1'b0, 24'h20, 1'b0, 32'hDEADBEEF);
        waitDrain();

        // Halfword store aborted by reset during its WRITE cycle
        req_write  = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 24'h24;
        req_wdata  = 32'h00001111;
        req_valid  = 1'b1;
        check("abort req_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort mem_we", mem_we, 1'b0);
        check("abort resp_valid", resp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post-abort req_ready", req_ready, 1'b1);
        check("post-abort resp_valid", resp_valid, 1'b0);
        check("post-abort mem_we", mem_we, 1'b0);
        check("abort memory intact", mem[9], 32'hAAAABBBB);
        repeat (3) @(negedge clk);
        doLoad(2'b10, 1'b0, 24'h24, 1'b0, 32'hAAAABBBB);
        waitDrain();

        // Back-to-back requests with req_valid held high throughout
        holdValid = 1'b1;
        doLoad(2'b10, 1'b0, 24'h10, 1'b0, 32'h1122AB44);
        doStore(2'b00, 24'h23, 32'h0000005A, 1'b0, 22'd8, 32'h5AADBEEF);
        doLoad(2'b01, 1'b0, 24'h01, 1'b1, 32'h0);
        doLoad(2'b00, 1'b0, 24'h23, 1'b0, 32'h0000005A);
        holdValid = 1'b0;
        doLoad(2'b10, 1'b0, 24'h20, 1'b0, 32'h5AADBEEF);
        waitDrain();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
